// File: rtl/fmul64_rsh_round.sv
// fmul64_rsh_round: right-shift rounding stage for subnormal F64 products.
// Two-stage valid/ready pipeline producing exp/frac/NX/UF.

module fmul64_rsh_lgs_mask (
  input  logic [5:0]   rsh_num,
  output logic [105:0] l_mask,
  output logic [105:0] g_mask,
  output logic [105:0] s_mask,
  output logic [105:0] l_uc_mask,
  output logic [105:0] g_uc_mask,
  output logic [105:0] s_uc_mask
);
  localparam logic [105:0] ONE = 106'd1;

  logic [6:0] sh_l;
  logic [6:0] sh_g;
  logic [6:0] sh_gu;

  assign sh_l  = 7'd52 + {1'b0, rsh_num};
  assign sh_g  = 7'd51 + {1'b0, rsh_num};
  assign sh_gu = 7'd50 + {1'b0, rsh_num};

  // Shifts past bit 105 give 0, so the sticky
  // mask wraps to all ones for large shifts.
  assign l_mask    = ONE << sh_l;
  assign g_mask    = ONE << sh_g;
  assign s_mask    = g_mask - ONE;
  assign l_uc_mask = g_mask;
  assign g_uc_mask = ONE << sh_gu;
  assign s_uc_mask = g_uc_mask - ONE;
endmodule

module fmul64_rsh_round (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [105:0] sig_mul_i,
  input  logic [5:0]   rsh_num_i,
  input  logic         sign_i,
  input  logic [2:0]   rm_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic         exp_o,
  output logic [51:0]  frac_o,
  output logic         inexact_o,
  output logic         underflow_o
);
  logic         s1_valid;
  logic         s2_valid;
  logic         s1_adv;
  logic         in_fire;

  logic [105:0] l_mask;
  logic [105:0] g_mask;
  logic [105:0] s_mask;
  logic [105:0] l_uc_mask;
  logic [105:0] g_uc_mask;
  logic [105:0] s_uc_mask;

  logic [6:0]   sh_l;
  logic [6:0]   sh_g;
  logic [52:0]  sig_rsh_d;
  logic [53:0]  uf_base_d;
  logic [2:0]   lgs_d;
  logic [2:0]   uc_d;

  logic [52:0]  s1_sig_rsh;
  logic [53:0]  s1_uf_base;
  logic [2:0]   s1_lgs;
  logic [2:0]   s1_uc;
  logic         s1_sign;
  logic [2:0]   s1_rm;

  logic         inc;
  logic         inc_uc;
  logic [52:0]  rnd;
  logic [53:0]  uf_sum;
  logic         tiny;
  logic         nx;

  function automatic logic rnd_inc(
    input logic [2:0] t,
    input logic       sgn,
    input logic [2:0] rm
  );
    logic l;
    logic g;
    logic s;
    logic r;
    l = t[2];
    g = t[1];
    s = t[0];
    case (rm)
      3'd1:    r = 1'b0;
      3'd2:    r = (g | s) & sgn;
      3'd3:    r = (g | s) & ~sgn;
      3'd4:    r = g;
      default: r = g & (l | s);
    endcase
    return r;
  endfunction

  assign s1_adv      = ~s2_valid | out_ready_i;
  assign in_ready_o  = ~s1_valid | s1_adv;
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_valid_o = s2_valid;

  fmul64_rsh_lgs_mask u_mask (
    .rsh_num   (rsh_num_i),
    .l_mask    (l_mask),
    .g_mask    (g_mask),
    .s_mask    (s_mask),
    .l_uc_mask (l_uc_mask),
    .g_uc_mask (g_uc_mask),
    .s_uc_mask (s_uc_mask)
  );

  assign sh_l      = 7'd52 + {1'b0, rsh_num_i};
  assign sh_g      = 7'd51 + {1'b0, rsh_num_i};
  assign sig_rsh_d = 53'(sig_mul_i >> sh_l);
  assign uf_base_d = 54'(sig_mul_i >> sh_g);

  assign lgs_d = {|(sig_mul_i & l_mask),
                  |(sig_mul_i & g_mask),
                  |(sig_mul_i & s_mask)};
  assign uc_d  = {|(sig_mul_i & l_uc_mask),
                  |(sig_mul_i & g_uc_mask),
                  |(sig_mul_i & s_uc_mask)};

  assign inc    = rnd_inc(s1_lgs, s1_sign, s1_rm);
  assign inc_uc = rnd_inc(s1_uc, s1_sign, s1_rm);
  assign rnd    = s1_sig_rsh + {52'd0, inc};
  assign uf_sum = s1_uf_base + {53'd0, inc_uc};
  assign tiny   = ~1'(uf_sum >> 53);
  assign nx     = s1_lgs[1] | s1_lgs[0];

  // Stage-1 occupancy; flush wins over a same-cycle transfer.
  always_ff @(posedge clk) begin
    if (rst)          s1_valid <= 1'b0;
    else if (flush_i) s1_valid <= 1'b0;
    else if (in_fire) s1_valid <= 1'b1;
    else if (s1_adv)  s1_valid <= 1'b0;
  end

  // Stage-1 payload: shifted significand and L/G/S triplets.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_sig_rsh <= '0;
      s1_uf_base <= '0;
      s1_lgs     <= '0;
      s1_uc      <= '0;
      s1_sign    <= 1'b0;
      s1_rm      <= '0;
    end else if (in_fire) begin
      s1_sig_rsh <= sig_rsh_d;
      s1_uf_base <= uf_base_d;
      s1_lgs     <= lgs_d;
      s1_uc      <= uc_d;
      s1_sign    <= sign_i;
      s1_rm      <= rm_i;
    end
  end

  // Stage-2 occupancy follows stage 1 whenever it may advance.
  always_ff @(posedge clk) begin
    if (rst)          s2_valid <= 1'b0;
    else if (flush_i) s2_valid <= 1'b0;
    else if (s1_adv)  s2_valid <= s1_valid;
  end

  // Stage-2 rounded result; held stable while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_o       <= 1'b0;
      frac_o      <= '0;
      inexact_o   <= 1'b0;
      underflow_o <= 1'b0;
    end else if (s1_adv & s1_valid) begin
      exp_o       <= rnd[52];
      frac_o      <= rnd[51:0];
      inexact_o   <= nx;
      underflow_o <= tiny & nx;
    end
  end

  a_rsh_nz: assert property (
    @(posedge clk) disable iff (rst)
    !(in_valid_i && (rsh_num_i == 6'd0)));
endmodule

// File: tb/tb_fmul64_rsh_round.sv
// tb_fmul64_rsh_round: directed bench for fmul64_rsh_round.
// Each task drives one scenario and checks inline.

module tb_fmul64_rsh_round;
  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [105:0] sig;
  logic [5:0]   rsh;
  logic         sign;
  logic [2:0]   rm;
  logic         out_valid;
  logic         out_ready;
  logic         exp_f;
  logic [51:0]  frac;
  logic         nx;
  logic         uf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fmul64_rsh_round dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .sig_mul_i   (sig),
    .rsh_num_i   (rsh),
    .sign_i      (sign),
    .rm_i        (rm),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .exp_o       (exp_f),
    .frac_o      (frac),
    .inexact_o   (nx),
    .underflow_o (uf)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    sig = '0; rsh = 6'd1; sign = 1'b0; rm = 3'd0;
    out_ready = 1'b1;
    tick; tick;
    checks++;
    if (out_valid !== 1'b0)
      $display("FAIL reset_valid: got %b want 0", out_valid);
    if (out_valid !== 1'b0) errors++;
    checks++;
    if ({exp_f, frac, nx, uf} !== 55'd0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0",
               {exp_f, frac, nx, uf});
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", in_ready);
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_vectors;
    logic [105:0] vs [11];
    logic [5:0]   vr [11];
    logic         vg [11];
    logic [2:0]   vm [11];
    logic [54:0]  ve [11];
    logic [105:0] ones;
    ones = {1'b0, {105{1'b1}}};
    // {exp, frac, nx, uf}
    vs[0]  = 106'd1 << 104; vr[0]  = 6'd1;  vg[0]  = 0; vm[0]  = 3'd0;
    ve[0]  = {1'b0, 52'h8_0000_0000_0000, 2'b00};
    vs[1]  = ones;          vr[1]  = 6'd1;  vg[1]  = 0; vm[1]  = 3'd0;
    ve[1]  = {1'b1, 52'h0, 2'b10};
    vs[2]  = 106'd1 << 105; vr[2]  = 6'd54; vg[2]  = 0; vm[2]  = 3'd0;
    ve[2]  = {1'b0, 52'h0, 2'b11};
    vs[3]  = 106'd1 << 105; vr[3]  = 6'd54; vg[3]  = 0; vm[3]  = 3'd3;
    ve[3]  = {1'b0, 52'h1, 2'b11};
    vs[4]  = 106'd1 << 105; vr[4]  = 6'd54; vg[4]  = 0; vm[4]  = 3'd2;
    ve[4]  = {1'b0, 52'h0, 2'b11};
    vs[5]  = 106'd1 << 105; vr[5]  = 6'd60; vg[5]  = 1; vm[5]  = 3'd2;
    ve[5]  = {1'b0, 52'h1, 2'b11};
    vs[6]  = ones;          vr[6]  = 6'd1;  vg[6]  = 0; vm[6]  = 3'd1;
    ve[6]  = {1'b0, 52'hF_FFFF_FFFF_FFFF, 2'b11};
    vs[7]  = (106'd1 << 104) | (106'd1 << 53);
    vr[7]  = 6'd2;  vg[7]  = 0; vm[7]  = 3'd4;
    ve[7]  = {1'b0, 52'h4_0000_0000_0001, 2'b11};
    vs[8]  = (106'd1 << 104) | (106'd1 << 53);
    vr[8]  = 6'd2;  vg[8]  = 0; vm[8]  = 3'd5;
    ve[8]  = {1'b0, 52'h4_0000_0000_0000, 2'b11};
    vs[9]  = 106'd1 << 105; vr[9]  = 6'd55; vg[9]  = 0; vm[9]  = 3'd0;
    ve[9]  = {1'b0, 52'h0, 2'b11};
    vs[10] = 106'd3 << 104; vr[10] = 6'd54; vg[10] = 0; vm[10] = 3'd0;
    ve[10] = {1'b0, 52'h1, 2'b11};
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      sig = vs[i]; rsh = vr[i]; sign = vg[i]; rm = vm[i];
      in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL vec%0d_early: got %b want 0", i, out_valid);
      end
      tick;
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL vec%0d_valid: got %b want 1", i, out_valid);
      end
      checks++;
      if ({exp_f, frac, nx, uf} !== ve[i]) begin
        errors++;
        $display("FAIL vec%0d_data: got %h want %h",
                 i, {exp_f, frac, nx, uf}, ve[i]);
      end
    end
    tick;
  endtask

  task automatic test_back_to_back;
    int sent = 0;
    int recv = 0;
    int occ = 0;
    int cyc = 0;
    logic stalled = 1'b0;
    logic [54:0] held = '0;
    logic in_f;
    logic out_f;
    logic rdy_exp;
    while (recv < 8 && cyc < 40) begin
      out_ready = !(cyc >= 3 && cyc <= 5);
      if (sent < 8) begin
        in_valid = 1'b1;
        sig = 106'(sent + 1) << 53;
        rsh = 6'd1; sign = 1'b0; rm = 3'd0;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 ||
            {exp_f, frac, nx, uf} !== held) begin
          errors++;
          $display("FAIL b2b_stall: got %b/%h want 1/%h",
                   out_valid, {exp_f, frac, nx, uf}, held);
        end
      end
      rdy_exp = (occ < 2) || out_ready;
      checks++;
      if (in_ready !== rdy_exp) begin
        errors++;
        $display("FAIL b2b_ready cyc%0d: got %b want %b",
                 cyc, in_ready, rdy_exp);
      end
      in_f  = in_valid & in_ready;
      out_f = out_valid & out_ready;
      if (out_f) begin
        checks++;
        if ({exp_f, frac, nx, uf} !==
            {1'b0, 52'(recv + 1), 2'b00}) begin
          errors++;
          $display("FAIL b2b_data%0d: got %h want %h", recv,
                   {exp_f, frac, nx, uf},
                   {1'b0, 52'(recv + 1), 2'b00});
        end
        recv++;
      end
      stalled = out_valid & ~out_ready;
      held = {exp_f, frac, nx, uf};
      if (in_f) sent++;
      occ = occ + int'(in_f) - int'(out_f);
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (recv != 8 || sent != 8) begin
      errors++;
      $display("FAIL b2b_count: got %0d/%0d want 8/8", sent, recv);
    end
    tick;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_extra: got %b want 0", out_valid);
    end
  endtask

  task automatic test_flush;
    logic seen = 1'b0;
    rsh = 6'd1; sign = 1'b0; rm = 3'd0;
    out_ready = 1'b0;
    in_valid = 1'b1; sig = 106'd11 << 53;
    tick;
    sig = 106'd12 << 53;
    tick;
    sig = 106'd13 << 53;
    flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready_full: got %b want 0", in_ready);
    end
    tick;
    flush = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_valid: got %b want 0", out_valid);
    end
    sig = 106'd14 << 53;
    in_valid = 1'b1; flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_ready_empty: got %b want 1", in_ready);
    end
    tick;
    in_valid = 1'b0; flush = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid) seen = 1'b1;
      tick;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL flush_leak: got %b want 0", seen);
    end
    sig = 106'd5 << 53; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    checks++;
    if (out_valid !== 1'b1 || frac !== 52'd5) begin
      errors++;
      $display("FAIL flush_after: got %b/%h want 1/5",
               out_valid, frac);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    logic seen = 1'b0;
    rsh = 6'd1; sign = 1'b0; rm = 3'd0;
    out_ready = 1'b0;
    in_valid = 1'b1; sig = 106'd21 << 53;
    tick;
    sig = 106'd22 << 53;
    tick;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_full: got %b/%b want 1/0",
               out_valid, in_ready);
    end
    rst = 1'b1;
    tick;
    checks++;
    if ({out_valid, exp_f, frac, nx, uf} !== 56'd0) begin
      errors++;
      $display("FAIL rstmid_out: got %h want 0",
               {out_valid, exp_f, frac, nx, uf});
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_ready: got %b want 1", in_ready);
    end
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (out_valid) seen = 1'b1;
      tick;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_leak: got %b want 0", seen);
    end
    sig = 106'd7 << 53; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    checks++;
    if (out_valid !== 1'b1 ||
        {exp_f, frac, nx, uf} !== {1'b0, 52'd7, 2'b00}) begin
      errors++;
      $display("FAIL rstmid_after: got %b/%h want 1/%h",
               out_valid, {exp_f, frac, nx, uf},
               {1'b0, 52'd7, 2'b00});
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_back_to_back;
    test_flush;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
